// File: rtl/polar_stats_pkg.sv
// Shared types and helpers for the polar-stream frame statistics engine.
package polar_stats_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  // Modulo-2^w phase difference, returned sign-extended to 32 bits so the
  // caller can truncate to any accumulator width up to 32.
  function automatic logic signed [31:0] wrap_diff(
    input logic [31:0] cur,
    input logic [31:0] prev,
    input int          w
  );
    logic [31:0] raw;
    raw = (cur - prev) << (32 - w);
    return $signed(raw) >>> (32 - w);
  endfunction

endpackage

// File: rtl/polar_frame_stats.sv
// Per-frame magnitude sum, peak/index and accumulated phase difference
// over the CORDIC polar stream, delivered through a one-deep valid/ready register.
module polar_frame_stats
  import polar_stats_pkg::*;
#(
  parameter int OW        = 10,
  parameter int FRAME_LEN = 256,
  parameter int LW        = $clog2(FRAME_LEN)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic             i_sync,
  input  logic [OW-1:0]    i_mag,
  input  logic [OW-1:0]    i_phase,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [OW+LW-1:0] o_mag_sum,
  output logic [OW-1:0]    o_peak_mag,
  output logic [LW-1:0]    o_peak_idx,
  output logic [OW+LW-1:0] o_dphase_sum,
  output logic             o_resync,
  output logic             o_overrun
);

  localparam int SW = OW + LW;

  state_t          state, state_nxt;
  logic [LW-1:0]   cnt;
  logic [SW-1:0]   acc_sum, sum_nxt;
  logic [OW-1:0]   acc_peak, peak_nxt;
  logic [LW-1:0]   acc_idx, idx_nxt;
  logic [SW-1:0]   acc_dph, dph_nxt;
  logic [OW-1:0]   prev_phase;
  logic signed [31:0] d_full;
  logic [SW-1:0]   d_ext;
  logic            start, acc_take, frame_done, out_load;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    start      = i_valid & i_sync;
    acc_take   = i_valid & ~i_sync & (state == ACC);
    frame_done = acc_take & (cnt == LW'(FRAME_LEN - 1));
    state_nxt  = state;
    case (state)
      IDLE:    if (start)      state_nxt = ACC;
      ACC:     if (frame_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    d_full   = wrap_diff(32'(i_phase), 32'(prev_phase), OW);
    d_ext    = d_full[SW-1:0];
    sum_nxt  = acc_sum + SW'(i_mag);
    peak_nxt = (i_mag > acc_peak) ? i_mag : acc_peak;
    idx_nxt  = (i_mag > acc_peak) ? cnt : acc_idx;
    dph_nxt  = acc_dph + d_ext;
    out_load = frame_done & (~o_valid | i_ready);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // A sync always restarts the frame, whether from IDLE or mid-frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt        <= '0;
      acc_sum    <= '0;
      acc_peak   <= '0;
      acc_idx    <= '0;
      acc_dph    <= '0;
      prev_phase <= '0;
    end else if (start) begin
      cnt        <= LW'(1);
      acc_sum    <= SW'(i_mag);
      acc_peak   <= i_mag;
      acc_idx    <= '0;
      acc_dph    <= '0;
      prev_phase <= i_phase;
    end else if (acc_take) begin
      cnt        <= cnt + LW'(1);
      acc_sum    <= sum_nxt;
      acc_peak   <= peak_nxt;
      acc_idx    <= idx_nxt;
      acc_dph    <= dph_nxt;
      prev_phase <= i_phase;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid      <= 1'b0;
      o_mag_sum    <= '0;
      o_peak_mag   <= '0;
      o_peak_idx   <= '0;
      o_dphase_sum <= '0;
      o_resync     <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_resync <= start & (state == ACC);
      if (out_load) begin
        o_valid      <= 1'b1;
        o_mag_sum    <= sum_nxt;
        o_peak_mag   <= peak_nxt;
        o_peak_idx   <= idx_nxt;
        o_dphase_sum <= dph_nxt;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
      // A completed frame that cannot load is lost; flag it until reset.
      if (frame_done & ~out_load) o_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_polar_frame_stats.sv
// Scoreboard bench for polar_frame_stats: frame-level reference model in the
// driver, independent monitor comparing every presented result.
module tb_polar_frame_stats;

  localparam int OW = 10;
  localparam int FL = 8;
  localparam int LW = 3;
  localparam int SW = OW + LW;

  typedef struct {
    logic [SW-1:0] sum;
    logic [OW-1:0] peak;
    logic [LW-1:0] idx;
    logic [SW-1:0] dph;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0, i_sync = 1'b0, i_ready = 1'b0;
  logic [OW-1:0] i_mag = '0, i_phase = '0;
  logic          o_valid, o_resync, o_overrun;
  logic [SW-1:0] o_mag_sum, o_dphase_sum;
  logic [OW-1:0] o_peak_mag;
  logic [LW-1:0] o_peak_idx;

  polar_frame_stats #(.OW(OW), .FRAME_LEN(FL), .LW(LW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_sync(i_sync),
    .i_mag(i_mag), .i_phase(i_phase), .o_valid(o_valid), .i_ready(i_ready),
    .o_mag_sum(o_mag_sum), .o_peak_mag(o_peak_mag), .o_peak_idx(o_peak_idx),
    .o_dphase_sum(o_dphase_sum), .o_resync(o_resync), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state (driver side), committed after each clock edge.
  res_t exp_q[$];
  bit   mvalid = 0, exp_resync = 0, exp_overrun = 0;
  bit   in_frame = 0;
  int   fr_mag[$], fr_ph[$];
  bit   pend_push = 0, pend_resync = 0, pend_overrun = 0, next_mvalid = 0;
  res_t pend_res;

  function automatic res_t model_frame();
    res_t r;
    int s = 0, pk = -1, ix = 0, ds = 0, d;
    for (int i = 0; i < FL; i++) begin
      s += fr_mag[i];
      if (fr_mag[i] > pk) begin pk = fr_mag[i]; ix = i; end
      if (i > 0) begin
        d = (fr_ph[i] - fr_ph[i-1] + 1024) % 1024;
        if (d >= 512) d -= 1024;
        ds += d;
      end
    end
    r.sum  = SW'(s);
    r.peak = OW'(pk);
    r.idx  = LW'(ix);
    r.dph  = SW'(ds);
    return r;
  endfunction

  task automatic commit();
    if (pend_push) exp_q.push_back(pend_res);
    mvalid     = next_mvalid;
    exp_resync = pend_resync;
    if (pend_overrun) exp_overrun = 1;
    pend_push = 0; pend_resync = 0; pend_overrun = 0;
  endtask

  task automatic step(input bit v, input bit s, input int m, input int p, input bit r);
    @(posedge clk); #1;
    commit();
    i_valid = v; i_sync = s; i_mag = OW'(m); i_phase = OW'(p); i_ready = r;
    next_mvalid = mvalid && !r ? 1'b1 : 1'b0;
    if (v) begin
      if (s) begin
        if (in_frame) pend_resync = 1;
        fr_mag.delete(); fr_ph.delete();
        fr_mag.push_back(m); fr_ph.push_back(p);
        in_frame = 1;
      end else if (in_frame) begin
        fr_mag.push_back(m); fr_ph.push_back(p);
        if (fr_mag.size() == FL) begin
          pend_res = model_frame();
          in_frame = 0;
          if (!mvalid || r) begin
            pend_push   = 1;
            next_mvalid = 1;
          end else begin
            pend_overrun = 1;
          end
        end
      end
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    commit();
    rst_n = 0;
    i_valid = 0; i_sync = 0; i_ready = 0;
    mvalid = 0; exp_resync = 0; exp_overrun = 0; in_frame = 0; next_mvalid = 0;
    exp_q.delete(); fr_mag.delete(); fr_ph.delete();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic frame(input int m[FL], input int p[FL], input bit r_body, input bit r_last);
    for (int i = 0; i < FL; i++)
      step(1, i == 0, m[i], p[i], (i == FL-1) ? r_last : r_body);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, r);
  endtask

  // Monitor: decoupled from stimulus, samples on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_valid", 32'(o_valid), 0);
      check("rst_sum", 32'(o_mag_sum), 0);
      check("rst_peak", 32'(o_peak_mag), 0);
      check("rst_idx", 32'(o_peak_idx), 0);
      check("rst_dph", 32'(o_dphase_sum), 0);
      check("rst_resync", 32'(o_resync), 0);
      check("rst_overrun", 32'(o_overrun), 0);
    end else begin
      check("valid", 32'(o_valid), 32'(mvalid));
      check("resync", 32'(o_resync), 32'(exp_resync));
      check("overrun", 32'(o_overrun), 32'(exp_overrun));
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(o_valid), 0);
        end else begin
          check("mag_sum", 32'(o_mag_sum), 32'(exp_q[0].sum));
          check("peak_mag", 32'(o_peak_mag), 32'(exp_q[0].peak));
          check("peak_idx", 32'(o_peak_idx), 32'(exp_q[0].idx));
          check("dphase_sum", 32'(o_dphase_sum), 32'(exp_q[0].dph));
          if (i_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int m[FL], p[FL];
    int n;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Constant magnitude, linear phase ramp.
    for (int i = 0; i < FL; i++) begin m[i] = 100; p[i] = 4 * i; end
    frame(m, p, 1, 1);
    idle(2, 1);

    // Ascending phase across the wrap point.
    for (int i = 0; i < FL; i++) begin m[i] = int'($urandom_range(1023)); p[i] = (1020 + 6 * i) % 1024; end
    frame(m, p, 1, 1);
    // Descending phase across the wrap point.
    for (int i = 0; i < FL; i++) begin m[i] = int'($urandom_range(1023)); p[i] = (1026 - 6 * i) % 1024; end
    frame(m, p, 1, 1);
    idle(2, 1);

    // Peak tie keeps the earlier index.
    m = '{5, 9, 3, 9, 1, 2, 3, 4};
    for (int i = 0; i < FL; i++) p[i] = int'($urandom_range(1023));
    frame(m, p, 1, 1);
    idle(2, 1);

    // Held result consumed in the same cycle the next frame completes.
    for (int i = 0; i < FL; i++) begin m[i] = 10 + i; p[i] = 3 * i; end
    frame(m, p, 0, 0);
    for (int i = 0; i < FL; i++) begin m[i] = 50 - i; p[i] = 1000 - i; end
    frame(m, p, 0, 1);
    idle(3, 0);
    idle(2, 1);

    // Two completions under backpressure: second is dropped.
    for (int i = 0; i < FL; i++) begin m[i] = int'($urandom_range(1023)); p[i] = int'($urandom_range(1023)); end
    frame(m, p, 0, 0);
    for (int i = 0; i < FL; i++) begin m[i] = int'($urandom_range(1023)); p[i] = int'($urandom_range(1023)); end
    frame(m, p, 0, 0);
    idle(3, 0);
    idle(2, 1);

    // Mid-frame sync at index 4 restarts the frame.
    apply_reset();
    for (int i = 0; i < 4; i++) step(1, i == 0, 900, 7 * i, 1);
    for (int i = 0; i < FL; i++) begin m[i] = 20 + i; p[i] = 500 + 9 * i; end
    frame(m, p, 1, 1);
    idle(2, 1);

    // Reset mid-frame, then unsynced samples are ignored.
    for (int i = 0; i < 4; i++) step(1, i == 0, 300 + i, 11 * i, 1);
    apply_reset();
    for (int i = 0; i < 10; i++) step(1, 0, int'($urandom_range(1023)), int'($urandom_range(1023)), 1);
    for (int i = 0; i < FL; i++) begin m[i] = int'($urandom_range(1023)); p[i] = int'($urandom_range(1023)); end
    frame(m, p, 1, 1);
    idle(2, 1);

    // Randomised traffic with back-to-back frames, random backpressure and syncs.
    n = 0;
    for (int i = 0; i < 400; i++) begin
      bit v, s;
      v = ($urandom_range(9) < 8);
      s = (!in_frame) ? ($urandom_range(2) == 0) : ($urandom_range(40) == 0);
      step(v, s, int'($urandom_range(1023)), int'($urandom_range(1023)), $urandom_range(1) == 1);
    end

    // Drain with a bounded wait.
    while ((exp_q.size() != 0 || mvalid || pend_push) && n < 50) begin
      step(0, 0, 0, 0, 1);
      n++;
    end
    idle(1, 1);
    check("drain_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
